// File: rtl/updown_sweep_pkg.sv
// Shared types for the up/down counter sweep sequencer.
//   sweep_mode_t  : command sweep mode (UP, DOWN, TRI; code 3 is reserved)
//   sweep_state_t : sequencer FSM state
//   MODE_RESERVED : raw mode code that is rejected at accept
package updown_sweep_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_TRI  = 2'd2
    } sweep_mode_t;

    localparam logic [1:0] MODE_RESERVED = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN_UP   = 3'd2,
        ST_RUN_DOWN = 3'd3,
        ST_DONE     = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/updown_sweep_ctrl.sv
// Command-driven sequencer that loads and steps an external N-bit up/down
// counter up, down or in a triangle between two bounds.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_lo, cmd_hi, cmd_mode,    sweep bounds, mode, TRI period count
//   cmd_reps                     (reps 0 = run until abort)
//   abort                        synchronous stop request
//   cnt_q, cnt_carry_b           counter value and active-low terminal flag
//   cnt_up, cnt_enable_b,        counter direction, enable, load strobe and
//   cnt_set_b, cnt_set           load value (combinational from state and q)
//   busy, done, err, periods     status: active, one-cycle done, error pulse,
//                                completed TRI periods
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned R = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_lo,
    input  logic [N-1:0] cmd_hi,
    input  logic [1:0]   cmd_mode,
    input  logic [R-1:0] cmd_reps,
    input  logic         abort,
    input  logic [N-1:0] cnt_q,
    input  logic         cnt_carry_b,
    output logic         cnt_up,
    output logic         cnt_enable_b,
    output logic         cnt_set_b,
    output logic [N-1:0] cnt_set,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [R-1:0] periods
);

    sweep_state_t state_q, state_d;
    sweep_mode_t  mode_q;
    logic [N-1:0] lo_q, hi_q;
    logic [R-1:0] reps_q, periods_d;
    logic         done_d, err_d;

    logic         accept_c, bad_cmd_c;
    logic         at_hi_c, above_hi_c, at_lo_c, below_lo_c, tri_turn_c;
    logic         period_last_c;
    logic [R-1:0] periods_inc_c;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept_c  = cmd_valid && cmd_ready;
    assign bad_cmd_c = (cmd_lo > cmd_hi) || (cmd_mode == MODE_RESERVED);

    // Bound comparators against the live counter value
    assign at_hi_c       = (cnt_q == hi_q);
    assign above_hi_c    = (cnt_q > hi_q);
    assign at_lo_c       = (cnt_q == lo_q);
    assign below_lo_c    = (cnt_q < lo_q);
    assign tri_turn_c    = (mode_q == MODE_TRI) && (lo_q < hi_q);
    assign periods_inc_c = periods + R'(1);
    assign period_last_c = (reps_q != '0) && (periods_inc_c == reps_q);

    // Direction is decoded apart from the enable logic so the counter's
    // carry (which depends on direction) never feeds back into cnt_up.
    always_comb begin
        cnt_up = 1'b1;
        case (state_q)
            ST_RUN_UP:   cnt_up = !(at_hi_c && tri_turn_c);
            ST_RUN_DOWN: cnt_up = at_lo_c && (mode_q == MODE_TRI);
            default:     cnt_up = 1'b1;
        endcase
    end

    // Next state, counter strobes and status updates
    always_comb begin
        state_d      = state_q;
        cnt_enable_b = 1'b1;
        cnt_set_b    = 1'b1;
        cnt_set      = '0;
        periods_d    = periods;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    periods_d = '0;
                    if (bad_cmd_c) err_d   = 1'b1;
                    else           state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                cnt_set_b    = 1'b0;
                cnt_enable_b = 1'b0;
                cnt_set      = (mode_q == MODE_DOWN) ? hi_q : lo_q;
                state_d      = (mode_q == MODE_DOWN) ? ST_RUN_DOWN : ST_RUN_UP;
            end

            ST_RUN_UP: begin
                if (above_hi_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (!at_hi_c || tri_turn_c) begin
                    // Step up, or turn around at hi without a dwell cycle
                    if (!cnt_carry_b) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_enable_b = 1'b0;
                        if (at_hi_c) state_d = ST_RUN_DOWN;
                    end
                end else begin
                    state_d = ST_DONE;
                    if (mode_q == MODE_TRI) periods_d = R'(1);
                end
            end

            ST_RUN_DOWN: begin
                if (below_lo_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (!at_lo_c) begin
                    if (!cnt_carry_b) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_enable_b = 1'b0;
                    end
                end else if (mode_q == MODE_TRI) begin
                    periods_d = periods_inc_c;
                    if (period_last_c) begin
                        state_d = ST_DONE;
                    end else if (!cnt_carry_b) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_enable_b = 1'b0;
                        state_d      = ST_RUN_UP;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        // Abort overrides every terminal or guard decision outside IDLE
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            cnt_enable_b = 1'b1;
            cnt_set_b    = 1'b1;
            err_d        = 1'b0;
            periods_d    = periods;
        end

        done_d = (state_d == ST_DONE);
    end

    // State and status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
            err     <= 1'b0;
            periods <= '0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            err     <= err_d;
            periods <= periods_d;
        end
    end

    // Command latch; an invalid mode is never stored into the enum
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lo_q   <= '0;
            hi_q   <= '0;
            reps_q <= '0;
            mode_q <= MODE_UP;
        end else if (accept_c) begin
            lo_q   <= cmd_lo;
            hi_q   <= cmd_hi;
            reps_q <= cmd_reps;
            if (!bad_cmd_c) mode_q <= sweep_mode_t'(cmd_mode);
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl paired with a behavioural up/down counter.
module tb_updown_sweep_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned R = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_valid, cmd_ready;
    logic [N-1:0] cmd_lo, cmd_hi;
    logic [1:0]   cmd_mode;
    logic [R-1:0] cmd_reps;
    logic         abort;
    logic [N-1:0] q;
    logic         carry_b;
    logic         cnt_up, cnt_enable_b, cnt_set_b;
    logic [N-1:0] cnt_set;
    logic         busy, done, err;
    logic [R-1:0] periods;

    // External override of the counter (models another agent loading it)
    logic         ext_load;
    logic [N-1:0] ext_val;

    int n_chk  = 0;
    int n_fail = 0;

    int exp_q[$];
    int exp_p[$];
    int exp_final_p;

    always #5 clock = ~clock;

    updown_sweep_ctrl #(.N(N), .R(R)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_lo       (cmd_lo),
        .cmd_hi       (cmd_hi),
        .cmd_mode     (cmd_mode),
        .cmd_reps     (cmd_reps),
        .abort        (abort),
        .cnt_q        (q),
        .cnt_carry_b  (carry_b),
        .cnt_up       (cnt_up),
        .cnt_enable_b (cnt_enable_b),
        .cnt_set_b    (cnt_set_b),
        .cnt_set      (cnt_set),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .periods      (periods)
    );

    // Behavioural up/down counter: no reset, load beats count
    always @(posedge clock) begin
        if (ext_load)        q <= ext_val;
        else if (!cnt_set_b) q <= cnt_set;
        else if (!cnt_enable_b) q <= cnt_up ? q + N'(1) : q - N'(1);
    end
    assign carry_b = !((cnt_up && (q == {N{1'b1}})) || (!cnt_up && (q == '0)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Reference: counter value after each edge from the load edge onward,
    // plus the periods count visible in that same cycle.
    function automatic void build_model(input int lo, input int hi, input int mode, input int reps);
        int cur;
        int pc;
        exp_q.delete();
        exp_p.delete();
        pc  = 0;
        cur = (mode == 1) ? hi : lo;
        exp_q.push_back(cur); exp_p.push_back(pc);
        if (mode == 0) begin
            while (cur < hi) begin cur++; exp_q.push_back(cur); exp_p.push_back(pc); end
        end else if (mode == 1) begin
            while (cur > lo) begin cur--; exp_q.push_back(cur); exp_p.push_back(pc); end
        end else if (lo == hi) begin
            pc = 1;
        end else begin
            for (int r = 0; r < reps; r++) begin
                while (cur < hi) begin cur++; exp_q.push_back(cur); exp_p.push_back(pc); end
                while (cur > lo) begin cur--; exp_q.push_back(cur); exp_p.push_back(pc); end
                pc++;
            end
        end
        exp_final_p = pc;
    endfunction

    task automatic do_sweep(input int lo, input int hi, input int mode, input int reps, input string tag);
        int n;
        build_model(lo, hi, mode, reps);
        n = exp_q.size();
        cmd_lo = N'(lo); cmd_hi = N'(hi); cmd_mode = 2'(mode); cmd_reps = R'(reps);
        cmd_valid = 1'b1;
        #1;
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        #1;
        chk({tag, " load set_b"}, 32'(cnt_set_b), 32'd0);
        chk({tag, " load value"}, 32'(cnt_set), exp_q[0]);
        chk({tag, " periods cleared"}, 32'(periods), 32'd0);
        for (int i = 0; i < n; i++) begin
            cyc();
            #1;
            chk({tag, " q"}, 32'(q), exp_q[i]);
            chk({tag, " periods"}, 32'(periods), exp_p[i]);
            chk({tag, " no early done"}, 32'(done), 32'd0);
            if (i < n - 1) begin
                chk({tag, " step enable"}, 32'(cnt_enable_b), 32'd0);
                chk({tag, " step dir"}, 32'(cnt_up), (exp_q[i+1] > exp_q[i]) ? 32'd1 : 32'd0);
            end else begin
                chk({tag, " stop enable"}, 32'(cnt_enable_b), 32'd1);
            end
        end
        cyc();
        #1;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " done busy"}, 32'(busy), 32'd1);
        chk({tag, " done q"}, 32'(q), exp_q[n-1]);
        chk({tag, " final periods"}, 32'(periods), exp_final_p);
        cyc();
        #1;
        chk({tag, " done drop"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, " hold q"}, 32'(q), exp_q[n-1]);
        chk({tag, " no err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reject(input int lo, input int hi, input int mode, input string tag);
        logic [N-1:0] q0;
        q0 = q;
        cmd_lo = N'(lo); cmd_hi = N'(hi); cmd_mode = 2'(mode); cmd_reps = R'(1);
        cmd_valid = 1'b1;
        #1;
        cyc();
        cmd_valid = 1'b0;
        #1;
        chk({tag, " err"}, 32'(err), 32'd1);
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, " set_b"}, 32'(cnt_set_b), 32'd1);
        chk({tag, " enable_b"}, 32'(cnt_enable_b), 32'd1);
        cyc();
        #1;
        chk({tag, " err drop"}, 32'(err), 32'd0);
        chk({tag, " q untouched"}, 32'(q), 32'(q0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int a, b, m, rp;

        reset = 1'b1; cmd_valid = 1'b0; cmd_lo = '0; cmd_hi = '0;
        cmd_mode = '0; cmd_reps = '0; abort = 1'b0;
        ext_load = 1'b1; ext_val = '0;
        cyc();
        ext_load = 1'b0;
        #1;
        chk("rst enable_b", 32'(cnt_enable_b), 32'd1);
        chk("rst set_b",    32'(cnt_set_b),    32'd1);
        chk("rst up",       32'(cnt_up),       32'd1);
        chk("rst set",      32'(cnt_set),      32'd0);
        chk("rst done",     32'(done),         32'd0);
        chk("rst err",      32'(err),          32'd0);
        chk("rst periods",  32'(periods),      32'd0);
        chk("rst busy",     32'(busy),         32'd0);
        cyc();
        reset = 1'b0;
        cyc();

        do_sweep(3, 5, 0, 0, "up3-5");
        do_sweep(1, 4, 1, 0, "down1-4");
        do_sweep(2, 4, 2, 2, "tri2-4x2");
        do_reject(6, 2, 0, "rej lo>hi");
        do_reject(1, 9, 3, "rej mode3");
        do_sweep(7, 7, 0, 0, "up7-7");
        do_sweep(5, 5, 2, 3, "tri5-5");
        do_sweep(0, 15, 0, 0, "up0-15");
        do_sweep(0, 15, 1, 0, "down15-0");

        // Abort while sweeping up through 9 in a continuous triangle
        cmd_lo = N'(0); cmd_hi = N'(15); cmd_mode = 2'(2); cmd_reps = R'(0);
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (q == N'(9)) found = 1'b1;
        end
        chk("abort reach q9", 32'(found), 32'd1);
        abort = 1'b1;
        #1;
        chk("abort enable_b", 32'(cnt_enable_b), 32'd1);
        chk("abort set_b",    32'(cnt_set_b),    32'd1);
        cyc();
        abort = 1'b0;
        #1;
        chk("abort idle",    32'(busy), 32'd0);
        chk("abort no done", 32'(done), 32'd0);
        chk("abort q hold",  32'(q),    32'd9);
        cyc();
        #1;
        chk("abort q stays", 32'(q),    32'd9);
        chk("abort no done2", 32'(done), 32'd0);

        // Async reset in the middle of a down sweep
        cmd_lo = N'(0); cmd_hi = N'(10); cmd_mode = 2'(1); cmd_reps = R'(0);
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        cyc(); cyc(); cyc();
        #1;
        chk("rd running", 32'(cnt_enable_b), 32'd0);
        reset = 1'b1;
        #1;
        chk("async rst enable_b", 32'(cnt_enable_b), 32'd1);
        chk("async rst busy",     32'(busy),         32'd0);
        #1;
        reset = 1'b0;
        a = int'(q);
        cyc();
        #1;
        chk("async rst q hold", 32'(q), 32'(a));
        chk("async rst done",   32'(done), 32'd0);

        // Range guard: counter forced above hi during RUN_UP
        cmd_lo = N'(0); cmd_hi = N'(10); cmd_mode = 2'(0); cmd_reps = R'(0);
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (q == N'(4)) found = 1'b1;
        end
        chk("guard reach q4", 32'(found), 32'd1);
        ext_val = N'(12); ext_load = 1'b1;
        cyc();
        ext_load = 1'b0;
        #1;
        chk("guard q forced", 32'(q), 32'd12);
        chk("guard enable_b", 32'(cnt_enable_b), 32'd1);
        chk("guard no err yet", 32'(err), 32'd0);
        cyc();
        #1;
        chk("guard err", 32'(err), 32'd1);
        chk("guard idle", 32'(cmd_ready), 32'd1);
        chk("guard q", 32'(q), 32'd12);
        cyc();
        #1;
        chk("guard err drop", 32'(err), 32'd0);
        chk("guard q hold", 32'(q), 32'd12);
        chk("guard no done", 32'(done), 32'd0);

        // Random legal sweeps against the reference model
        for (int t = 0; t < 20; t++) begin
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            m  = int'($urandom_range(0, 2));
            rp = int'($urandom_range(1, 3));
            if (a > b) do_sweep(b, a, m, rp, "rand");
            else       do_sweep(a, b, m, rp, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Command-driven sequencer for the N-bit up/down counter (active-low enable_b/set_b, active-low carry_b). It accepts a sweep command of bounds, mode and repeat count, loads the counter, and steps it up, down or in a triangle between the bounds. It sits beside the counter: it drives the counter's control inputs and observes q and carry_b.

Parameters:
N, 4, counter width; must match the paired counter.
R, 8, width of the repeat count and period counter.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high in IDLE only
cmd_lo  in  N  lower bound
cmd_hi  in  N  upper bound
cmd_mode  in  2  sweep_mode_t: UP=0, DOWN=1, TRI=2, 3 reserved
cmd_reps  in  R  TRI periods to run; 0 = continuous until abort
abort  in  1  synchronous stop request
cnt_q  in  N  counter value
cnt_carry_b  in  1  counter terminal flag, active low
cnt_up  out  1  counter direction, 1 = up
cnt_enable_b  out  1  counter enable, active low
cnt_set_b  out  1  counter load, active low
cnt_set  out  N  counter load value
busy  out  1  state != IDLE
done  out  1  high for exactly the one cycle spent in DONE
err  out  1  one-cycle pulse
periods  out  R  completed TRI periods; cleared on accept; wraps

Behaviour:
- Reset (async): state IDLE; cnt_enable_b=1, cnt_set_b=1, cnt_up=1, cnt_set=0; done=0, err=0, periods=0. Counter q is not reset and holds.
- Outputs to the counter are a combinational decode of registered state, latched command and cnt_q. This gives zero-lag stopping, with no overshoot. Default is enable_b=1, set_b=1.
- States: IDLE, LOAD, RUN_UP, RUN_DOWN, DONE.
- IDLE: a command is accepted when cmd_valid & cmd_ready; it latches lo, hi, mode and reps and clears periods.
  - If lo>hi or mode==3: err pulses next cycle, state stays IDLE, counter untouched.
  - Otherwise go to LOAD.
- LOAD (1 cycle): set_b=0, enable_b=0, cnt_set = hi if mode DOWN, else lo. Next state is RUN_DOWN for DOWN, RUN_UP otherwise.
- RUN_UP:
  - q!=hi: up=1, enable_b=0.
  - q==hi, mode UP: enable_b=1, go to DONE.
  - q==hi, mode TRI with lo<hi: up=0, enable_b=0 (turnaround costs no dwell cycle), go to RUN_DOWN.
  - q==hi, mode TRI with lo==hi: go to DONE, periods=1.
- RUN_DOWN:
  - q!=lo: up=0, enable_b=0.
  - q==lo, mode DOWN: go to DONE.
  - q==lo, mode TRI: periods increments. If reps!=0 and the new periods==reps, enable_b=1 and go to DONE. Otherwise up=1, enable_b=0 and go to RUN_UP.
- DONE: done=1 for one cycle, then IDLE.
- Range guard:
  - RUN_UP with q>hi, or RUN_DOWN with q<lo: enable_b=1, err pulse, go to IDLE.
  - cnt_carry_b=0 while a step in that direction is requested: same action.
- abort has highest priority in any non-IDLE state. That cycle enable_b=1 and set_b=1, and state goes to IDLE. done is not raised. abort in IDLE is ignored.
- Simultaneous abort and terminal condition: abort wins.
- Latency: the first count edge is 2 cycles after accept. A single sweep of k steps has done 2+k+1 cycles after accept.

Decomposition:
- Package updown_sweep_pkg:
  - sweep_mode_t enum (2-bit)
  - sweep_state_t enum
  - MODE_RESERVED constant
- No RTL sub-module: the FSM and comparators are a single module. The bench instantiates the existing up/down counter alongside it with N matching.

Test Plan:
- Single up sweep: lo=3, hi=5, mode UP, accept at cycle 0. LOAD at c1; q after each edge is 3,4,5. done at c5. cnt_enable_b=1 while q==5. q stays 5 afterwards.
- Single down sweep: lo=1, hi=4, mode DOWN. q sequence is 4,3,2,1 and then holds. done is exactly one cycle and busy falls with it.
- Triangle: lo=2, hi=4, reps=2. q sequence is 2,3,4,3,2,3,4,3,2. periods goes 1 then 2. done 11 cycles after accept. No dwell cycle at 4.
- Reject and degenerate:
  - lo=6, hi=2 gives an err pulse, no set_b/enable_b activity, cmd_ready high again the next cycle.
  - mode=3 gives the same result.
  - lo=hi=7 with mode UP: LOAD q=7, done 3 cycles after accept.
- Abort and reset: TRI with reps=0 on lo=0, hi=15, abort at q=9 going up. The counter holds 9, no done, IDLE next cycle. Async reset mid-RUN_DOWN forces enable_b=1 immediately, without waiting for a clock edge.
- Range guard: force the counter to q=12 during RUN_UP with hi=10 (external load). err pulses, the controller goes to IDLE and q is not modified further.
